// File: rtl/os_frame_ctrl.sv
// Frame sequencer between the sample source, overlap_save and the FFT engine.
// Optional FFT watchdog enabled by defining OS_CTRL_TIMEOUT_EN.
module os_frame_ctrl #(
   parameter int N_FFT     = 32,
   parameter int N_OVERLAP = 16,
   parameter int NB_FRAME  = 16,
   parameter int NB_OVR    = 8,
   parameter int TIMEOUT   = 256
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_valid,
   input  logic                i_os_valid,
   input  logic                i_fft_ready,
   input  logic                i_fft_done,
   output logic                o_os_valid,
   output logic                o_os_enable,
   output logic                o_os_clear,
   output logic                o_fft_start,
   output logic                o_busy,
   output logic [2:0]          o_state,
   output logic [NB_FRAME-1:0] o_frame_cnt,
   output logic [NB_OVR-1:0]   o_ovr_cnt,
   output logic                o_overrun,
   output logic                o_timeout
);

   localparam int NB_CNT = (N_FFT > 1) ? $clog2(N_FFT) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      RUN   = 3'd2,
      BUSY  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   if (N_OVERLAP <= 0 || N_OVERLAP >= N_FFT || TIMEOUT < 1) begin : g_bad_params
      $error("os_frame_ctrl: need 0 < N_OVERLAP < N_FFT and TIMEOUT >= 1");
   end

   state_t              state_reg, state_next;
   logic [NB_CNT-1:0]   cnt_reg, cnt_next;
   logic                enable_reg;
   logic                clear_reg, clear_next;
   logic                start_reg, start_next;
   logic [NB_FRAME-1:0] frame_reg, frame_next;
   logic [NB_OVR-1:0]   ovr_reg, ovr_next;
   logic                overrun_reg, overrun_next;
   logic                accept;
   logic                drop;
   logic                wd_expired;

`ifdef OS_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_reg;
   logic            timeout_reg, timeout_next;

   assign wd_expired = (wd_reg == WD_W'(TIMEOUT - 1));

   // Restart the watchdog whenever a new FFT job begins or BUSY/DRAIN is entered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wd_reg      <= '0;
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= timeout_next;
         if ((state_next == BUSY || state_next == DRAIN) &&
             (state_next != state_reg || start_next))
            wd_reg <= '0;
         else if (state_reg == BUSY || state_reg == DRAIN)
            wd_reg <= wd_reg + 1'b1;
      end
   end

   assign o_timeout = timeout_reg;
`else
   assign wd_expired = 1'b0;
   assign o_timeout  = 1'b0;
`endif

   assign accept = i_valid & enable_reg;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      clear_next   = 1'b0;
      start_next   = 1'b0;
      frame_next   = frame_reg;
      ovr_next     = ovr_reg;
      overrun_next = overrun_reg;
      drop         = 1'b0;
`ifdef OS_CTRL_TIMEOUT_EN
      timeout_next = timeout_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (i_start) begin
               state_next   = PRIME;
               clear_next   = 1'b1;
               cnt_next     = '0;
               frame_next   = '0;
               ovr_next     = '0;
               overrun_next = 1'b0;
`ifdef OS_CTRL_TIMEOUT_EN
               timeout_next = 1'b0;
`endif
            end
         end
         PRIME: begin
            if (i_stop)
               state_next = IDLE;
            else if (accept) begin
               if (cnt_reg == NB_CNT'(N_FFT - 1)) begin
                  state_next = RUN;
                  cnt_next   = '0;
               end else
                  cnt_next = cnt_reg + 1'b1;
            end
         end
         RUN: begin
            if (i_stop)
               state_next = IDLE;
            else if (i_os_valid) begin
               if (i_fft_ready) begin
                  start_next = 1'b1;
                  frame_next = frame_reg + 1'b1;
                  state_next = BUSY;
               end else
                  drop = 1'b1;
            end
         end
         BUSY: begin
            if (i_stop)
               state_next = i_fft_done ? IDLE : DRAIN;
            else if (i_fft_done) begin
               // A frame landing on the done cycle is a normal RUN arrival.
               state_next = RUN;
               if (i_os_valid) begin
                  if (i_fft_ready) begin
                     start_next = 1'b1;
                     frame_next = frame_reg + 1'b1;
                     state_next = BUSY;
                  end else
                     drop = 1'b1;
               end
            end else begin
               drop = i_os_valid;
               if (wd_expired) begin
                  state_next = RUN;
`ifdef OS_CTRL_TIMEOUT_EN
                  timeout_next = 1'b1;
`endif
               end
            end
         end
         DRAIN: begin
            if (i_fft_done)
               state_next = IDLE;
            else if (wd_expired) begin
               state_next = IDLE;
`ifdef OS_CTRL_TIMEOUT_EN
               timeout_next = 1'b1;
`endif
            end
         end
         default: state_next = IDLE;
      endcase

      if (drop) begin
         overrun_next = 1'b1;
         if (ovr_reg != {NB_OVR{1'b1}})
            ovr_next = ovr_reg + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         enable_reg  <= 1'b0;
         clear_reg   <= 1'b0;
         start_reg   <= 1'b0;
         frame_reg   <= '0;
         ovr_reg     <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         // Enable follows the next state so it drops as soon as DRAIN or IDLE is entered.
         enable_reg  <= (state_next == PRIME) || (state_next == RUN) || (state_next == BUSY);
         clear_reg   <= clear_next;
         start_reg   <= start_next;
         frame_reg   <= frame_next;
         ovr_reg     <= ovr_next;
         overrun_reg <= overrun_next;
      end
   end

   assign o_os_valid  = i_valid & enable_reg;
   assign o_os_enable = enable_reg;
   assign o_os_clear  = clear_reg;
   assign o_fft_start = start_reg;
   assign o_busy      = (state_reg != IDLE);
   assign o_state     = state_reg;
   assign o_frame_cnt = frame_reg;
   assign o_ovr_cnt   = ovr_reg;
   assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_os_frame_ctrl.sv
// Self-checking bench for os_frame_ctrl: directed phases plus random traffic against a rule-level model.
// Emulates overlap_save frame strobes and an FFT with programmable latency.
module tb_os_frame_ctrl;

   localparam int N_FFT     = 32;
   localparam int N_OVERLAP = 16;
   localparam int HOP       = N_FFT - N_OVERLAP;
   localparam int NB_FRAME  = 16;
   localparam int NB_OVR    = 8;
   localparam int TIMEOUT   = 8;
   localparam int OVR_MAX   = (1 << NB_OVR) - 1;

   logic clk = 1'b0;
   logic rst, start, stop, valid, os_valid, fft_ready, fft_done;
   logic dut_os_valid, dut_os_enable, dut_os_clear, dut_fft_start, dut_busy, dut_overrun, dut_timeout;
   logic [2:0]          dut_state;
   logic [NB_FRAME-1:0] dut_frame_cnt;
   logic [NB_OVR-1:0]   dut_ovr_cnt;

   os_frame_ctrl #(
      .N_FFT(N_FFT), .N_OVERLAP(N_OVERLAP), .NB_FRAME(NB_FRAME), .NB_OVR(NB_OVR), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_valid(valid),
      .i_os_valid(os_valid), .i_fft_ready(fft_ready), .i_fft_done(fft_done),
      .o_os_valid(dut_os_valid), .o_os_enable(dut_os_enable), .o_os_clear(dut_os_clear),
      .o_fft_start(dut_fft_start), .o_busy(dut_busy), .o_state(dut_state),
      .o_frame_cnt(dut_frame_cnt), .o_ovr_cnt(dut_ovr_cnt), .o_overrun(dut_overrun),
      .o_timeout(dut_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model, states numbered as the documented encodings.
   int m_st = 0, m_primed = 0, m_frames = 0, m_ovr = 0, m_wd = 0;
   bit m_en = 0, m_clr = 0, m_go = 0, m_ovf = 0, m_to = 0;

   // Environment: stream position since the last start, pending frame strobe, FFT countdown.
   int acc_total = 0;
   bit frame_due = 0;
   int fft_lat = 10;
   int done_in = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("state", 32'(dut_state), m_st);
      chk("os_enable", 32'(dut_os_enable), 32'(m_en));
      chk("os_clear", 32'(dut_os_clear), 32'(m_clr));
      chk("fft_start", 32'(dut_fft_start), 32'(m_go));
      chk("busy", 32'(dut_busy), 32'(m_st != 0));
      chk("frame_cnt", 32'(dut_frame_cnt), m_frames);
      chk("ovr_cnt", 32'(dut_ovr_cnt), m_ovr);
      chk("overrun", 32'(dut_overrun), 32'(m_ovf));
      chk("timeout", 32'(dut_timeout), 32'(m_to));
   endtask

   task automatic model_step();
      bit acc, go, clr_n, drop;
      int nst;
      acc = valid && m_en;

      if (rst || (m_st == 0 && start)) begin
         acc_total = 0;
         frame_due = 0;
      end else begin
         frame_due = 0;
         if (acc) begin
            acc_total++;
            frame_due = (acc_total % HOP == 0);
         end
      end
      if (done_in >= 0) done_in--;

      if (rst) begin
         m_st = 0; m_primed = 0; m_frames = 0; m_ovr = 0; m_wd = 0;
         m_en = 0; m_clr = 0; m_go = 0; m_ovf = 0; m_to = 0;
         done_in = -1;
         return;
      end

      nst = m_st; go = 0; clr_n = 0; drop = 0;
      case (m_st)
         0: if (start) begin
               nst = 1; clr_n = 1; m_primed = 0;
               m_frames = 0; m_ovr = 0; m_ovf = 0; m_to = 0;
            end
         1: if (stop) nst = 0;
            else if (acc) begin
               m_primed++;
               if (m_primed == N_FFT) nst = 2;
            end
         2: if (stop) nst = 0;
            else if (os_valid) begin
               if (fft_ready) begin go = 1; nst = 3; end
               else drop = 1;
            end
         3: if (stop) nst = fft_done ? 0 : 4;
            else if (fft_done) begin
               nst = 2;
               if (os_valid) begin
                  if (fft_ready) begin go = 1; nst = 3; end
                  else drop = 1;
               end
            end else begin
               drop = os_valid;
`ifdef OS_CTRL_TIMEOUT_EN
               if (m_wd == TIMEOUT - 1) begin nst = 2; m_to = 1; end
`endif
            end
         4: if (fft_done) nst = 0;
`ifdef OS_CTRL_TIMEOUT_EN
            else if (m_wd == TIMEOUT - 1) begin nst = 0; m_to = 1; end
`endif
         default: nst = 0;
      endcase

      if (go) m_frames = (m_frames + 1) % (1 << NB_FRAME);
      if (drop) begin
         m_ovf = 1;
         if (m_ovr < OVR_MAX) m_ovr++;
      end
      m_wd  = ((nst == 3 || nst == 4) && (nst != m_st || go)) ? 0 : m_wd + 1;
      m_st  = nst;
      m_go  = go;
      m_clr = clr_n;
      m_en  = (nst >= 1 && nst <= 3);
      if (go) done_in = fft_lat;
   endtask

   // One clock: drive at the falling edge, check combinational path, clock, check registers.
   task automatic cycle(input bit v, input bit rdy, input bit st, input bit sp, input bit r);
      rst = r; start = st; stop = sp; valid = v; fft_ready = rdy;
      os_valid = frame_due;
      fft_done = (done_in == 0);
      #1;
      chk("os_valid_comb", 32'(dut_os_valid), 32'(v && m_en));
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      int n;
      int starts_seen;
      rst = 1; start = 0; stop = 0; valid = 0; os_valid = 0; fft_ready = 0; fft_done = 0;

      // Reset held 3 cycles with start/valid driven: everything must stay 0.
      cycle(0, 1, 1, 0, 1);
      cycle(1, 1, 1, 0, 1);
      cycle(1, 1, 0, 1, 1);

      // Start: state 0 -> 1 with a single os_clear pulse.
      cycle(1, 1, 1, 0, 0);
      chk("start_state", 32'(dut_state), 1);
      chk("start_clear", 32'(dut_os_clear), 1);
      cycle(1, 1, 1, 0, 0);
      chk("clear_single", 32'(dut_os_clear), 0);

      // Priming: frame after sample 16 is discarded, frame after sample 32 starts the FFT.
      n = 0;
      while (acc_total < 20 && n < 100) begin cycle(1, 1, 0, 0, 0); n++; end
      chk("prime_discard", 32'(dut_frame_cnt), 0);
      while (acc_total < 36 && n < 200) begin cycle(1, 1, 0, 0, 0); n++; end
      chk("first_frame", 32'(dut_frame_cnt), 1);

      // Steady state to 96 samples with FFT latency 10.
      while (acc_total < 96 && n < 300) begin cycle(1, 1, 0, 0, 0); n++; end
      repeat (15) cycle(0, 1, 0, 0, 0);
      chk("steady_frames", 32'(dut_frame_cnt), 5);
      chk("steady_ovr", 32'(dut_ovr_cnt), 0);

      // Overrun: FFT latency 20 loses the frame at sample 128.
      fft_lat = 20;
      n = 0;
      while (acc_total < 130 && n < 200) begin cycle(1, 1, 0, 0, 0); n++; end
      chk("ovr_flag", 32'(dut_overrun), 1);
      chk("ovr_count", 32'(dut_ovr_cnt), 1);
      fft_lat = 10;
      while (acc_total < 147 && n < 300) begin cycle(1, 1, 0, 0, 0); n++; end
      chk("after_ovr_frames", 32'(dut_frame_cnt), 7);
      chk("after_ovr_count", 32'(dut_ovr_cnt), 1);

      // Random traffic with occasional stop/start/reset and random FFT latency.
      for (int i = 0; i < 600; i++) begin
         bit st, sp, r;
         st = ($urandom_range(0, 39) == 0);
         sp = ($urandom_range(0, 59) == 0);
         r  = ($urandom_range(0, 299) == 0);
         if (m_go) fft_lat = $urandom_range(4, 24);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, st, sp, r);
      end

      // Stop in BUSY: enable drops at once, DRAIN until done, then no more starts.
      fft_lat = 10;
      n = 0;
      while (m_st != 0 && n < 100) begin cycle(0, 1, 0, 1, 0); n++; end
      cycle(1, 1, 1, 1, 0);
      chk("start_wins", 32'(dut_state), 1);
      n = 0;
      while (m_st != 3 && n < 200) begin cycle(1, 1, 0, 0, 0); n++; end
      chk("reach_busy", 32'(dut_state), 3);
      cycle(1, 1, 0, 1, 0);
      chk("drain_state", 32'(dut_state), 4);
      chk("drain_enable", 32'(dut_os_enable), 0);
      starts_seen = 0;
      n = 0;
      while (m_st != 0 && n < 40) begin
         cycle(1, 1, $urandom_range(0, 1) == 1, 1, 0);
         starts_seen += int'(dut_fft_start);
         n++;
      end
      chk("drain_idle", 32'(dut_state), 0);
      repeat (4) begin cycle(1, 1, 0, 0, 0); starts_seen += int'(dut_fft_start); end
      chk("no_start_after_stop", starts_seen, 0);

`ifdef OS_CTRL_TIMEOUT_EN
      // Watchdog: a start with no done returns to RUN 8 cycles later with the flag set.
      cycle(0, 1, 1, 0, 0);
      fft_lat = 1000;
      n = 0;
      while (m_st != 3 && n < 200) begin cycle(1, 1, 0, 0, 0); n++; end
      chk("wd_busy", 32'(dut_state), 3);
      repeat (TIMEOUT) cycle(0, 1, 0, 0, 0);
      chk("wd_timeout", 32'(dut_timeout), 1);
      chk("wd_run", 32'(dut_state), 2);
      done_in = -1;
`endif

      cycle(0, 1, 0, 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
